// File: rtl/traffic_pkg.sv
// rtl/traffic_pkg.sv - light encodings, phase enum and light decode shared by the sequencer
package traffic_pkg;

    localparam logic [1:0] LITE_RED    = 2'b00;
    localparam logic [1:0] LITE_YELLOW = 2'b01;
    localparam logic [1:0] LITE_GREEN  = 2'b10;

    typedef enum logic [2:0] {
        RED_TO_EW = 3'd0,
        EW_GREEN  = 3'd1,
        EW_YELLOW = 3'd2,
        RED_TO_NS = 3'd3,
        NS_GREEN  = 3'd4,
        NS_YELLOW = 3'd5
    } phase_t;

    typedef struct packed {
        logic [1:0] ew;
        logic [1:0] ns;
    } lites_t;

    // Cross head stays RED in every green/yellow phase, so only one head is ever lit.
    function automatic lites_t decode_lites(input phase_t p);
        lites_t l;
        l.ew = LITE_RED;
        l.ns = LITE_RED;
        case (p)
            EW_GREEN:  l.ew = LITE_GREEN;
            EW_YELLOW: l.ew = LITE_YELLOW;
            NS_GREEN:  l.ns = LITE_GREEN;
            NS_YELLOW: l.ns = LITE_YELLOW;
            default:   l = '{ew: LITE_RED, ns: LITE_RED};
        endcase
        return l;
    endfunction

endpackage

// File: rtl/traffic_phase_sequencer_if.sv
// rtl/traffic_phase_sequencer_if.sv - timebase, car requests and signal-head outputs
interface traffic_phase_sequencer_if;
    logic       tick;
    logic       ew_car;
    logic       ns_car;
    logic [1:0] ew_lite;
    logic [1:0] ns_lite;
    logic [2:0] phase;
    logic       phase_start;

    modport master (
        output tick, ew_car, ns_car,
        input  ew_lite, ns_lite, phase, phase_start
    );

    modport slave (
        input  tick, ew_car, ns_car,
        output ew_lite, ns_lite, phase, phase_start
    );
endinterface

// File: rtl/phase_timer.sv
// rtl/phase_timer.sv - tick-enabled phase counter with clear, saturation and duration compare
module phase_timer #(
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_tick,
    input  logic             i_clear,
    input  logic [CNT_W-1:0] i_sat,
    input  logic [CNT_W-1:0] i_dur,
    output logic [CNT_W-1:0] o_cnt,
    output logic             o_done
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (i_tick) begin
            if (i_clear)
                r_cnt <= '0;
            else if (r_cnt != i_sat)
                r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_cnt  = r_cnt;
    assign o_done = (r_cnt == i_dur);

endmodule

// File: rtl/traffic_phase_sequencer.sv
// rtl/traffic_phase_sequencer.sv - two-way intersection phase FSM with min/max green arbitration
module traffic_phase_sequencer
    import traffic_pkg::*;
#(
    parameter int GREEN_MIN = 4,
    parameter int GREEN_MAX = 8,
    parameter int YELLOW_T  = 2,
    parameter int ALL_RED_T = 1,
    parameter int CNT_W     = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    traffic_phase_sequencer_if.slave  bus
);

    localparam logic [CNT_W-1:0] L_GMIN = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] L_GMAX = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_RED  = CNT_W'(ALL_RED_T - 1);

    phase_t           r_state;
    phase_t           w_next;
    logic [CNT_W-1:0] w_cnt;
    logic [CNT_W-1:0] w_dur;
    logic [CNT_W-1:0] w_sat;
    logic             w_done;
    logic             w_clear;
    logic [1:0]       r_ew_lite;
    logic [1:0]       r_ns_lite;
    logic             r_phase_start;
    lites_t           w_lites;

    phase_timer #(.CNT_W(CNT_W)) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_tick  (bus.tick),
        .i_clear (w_clear),
        .i_sat   (w_sat),
        .i_dur   (w_dur),
        .o_cnt   (w_cnt),
        .o_done  (w_done)
    );

    always_comb begin
        w_next = r_state;
        w_dur  = L_RED;
        w_sat  = L_RED;
        case (r_state)
            RED_TO_EW: if (bus.tick && w_done) w_next = EW_GREEN;
            EW_GREEN: begin
                w_dur = L_GMAX;
                w_sat = L_GMAX;
                // Yield only once min green is served and the own side is idle or max green is reached.
                if (bus.tick && bus.ns_car && (w_cnt >= L_GMIN) && (!bus.ew_car || (w_cnt == L_GMAX)))
                    w_next = EW_YELLOW;
            end
            EW_YELLOW: begin
                w_dur = L_YEL;
                w_sat = L_YEL;
                if (bus.tick && w_done) w_next = RED_TO_NS;
            end
            RED_TO_NS: if (bus.tick && w_done) w_next = NS_GREEN;
            NS_GREEN: begin
                w_dur = L_GMAX;
                w_sat = L_GMAX;
                if (bus.tick && bus.ew_car && (w_cnt >= L_GMIN) && (!bus.ns_car || (w_cnt == L_GMAX)))
                    w_next = NS_YELLOW;
            end
            NS_YELLOW: begin
                w_dur = L_YEL;
                w_sat = L_YEL;
                if (bus.tick && w_done) w_next = RED_TO_EW;
            end
            default: w_next = RED_TO_EW;
        endcase
        w_clear = (w_next != r_state);
        w_lites = decode_lites(w_next);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= RED_TO_EW;
            r_ew_lite     <= LITE_RED;
            r_ns_lite     <= LITE_RED;
            r_phase_start <= 1'b0;
        end else begin
            r_state       <= w_next;
            r_ew_lite     <= w_lites.ew;
            r_ns_lite     <= w_lites.ns;
            r_phase_start <= w_clear;
        end
    end

    assign bus.ew_lite     = r_ew_lite;
    assign bus.ns_lite     = r_ns_lite;
    assign bus.phase       = r_state;
    assign bus.phase_start = r_phase_start;

    a_one_head_lit: assert property (@(posedge clk) disable iff (!rst_n)
        (r_ew_lite == LITE_RED) || (r_ns_lite == LITE_RED));

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// tb/tb_traffic_phase_sequencer.sv - scoreboard bench for the intersection phase sequencer
module tb_traffic_phase_sequencer;

    localparam int GREEN_MIN = 4;
    localparam int GREEN_MAX = 8;
    localparam int YELLOW_T  = 2;
    localparam int ALL_RED_T = 1;

    typedef struct packed {
        logic [2:0] ph;
        logic [1:0] ew;
        logic [1:0] ns;
        logic       ps;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    int   m_ph;
    int   m_el;
    int   n_cyc = 0;
    obs_t sb_q[$];

    always #5 clk = ~clk;

    traffic_phase_sequencer_if tif ();

    traffic_phase_sequencer #(
        .GREEN_MIN (GREEN_MIN),
        .GREEN_MAX (GREEN_MAX),
        .YELLOW_T  (YELLOW_T),
        .ALL_RED_T (ALL_RED_T),
        .CNT_W     (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tif)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", tag, obs, exp);
        end
    endtask

    function automatic obs_t exp_out(input int ph, input logic ps);
        obs_t o;
        o.ph = 3'(ph);
        o.ew = 2'b00;
        o.ns = 2'b00;
        o.ps = ps;
        case (ph)
            1: o.ew = 2'b10;
            2: o.ew = 2'b01;
            4: o.ns = 2'b10;
            5: o.ns = 2'b01;
            default: ;
        endcase
        return o;
    endfunction

    // Reference: m_el counts ticks already spent in the current phase.
    task automatic model_step(input logic t, input logic ew, input logic ns, output logic changed);
        logic go;
        int   served;
        go      = 1'b0;
        changed = 1'b0;
        served  = m_el + 1;
        if (t) begin
            case (m_ph)
                0, 3: go = (served >= ALL_RED_T);
                2, 5: go = (served >= YELLOW_T);
                1: go = ns && (served >= GREEN_MIN) && (!ew || served >= GREEN_MAX);
                4: go = ew && (served >= GREEN_MIN) && (!ns || served >= GREEN_MAX);
                default: go = 1'b0;
            endcase
            if (go) begin
                m_ph    = (m_ph + 1) % 6;
                m_el    = 0;
                changed = 1'b1;
            end else begin
                m_el = served;
            end
        end
    endtask

    task automatic cyc(input logic t, input logic ew, input logic ns);
        logic changed;
        obs_t got;
        obs_t exp;
        tif.tick   = t;
        tif.ew_car = ew;
        tif.ns_car = ns;
        model_step(t, ew, ns, changed);
        sb_q.push_back(exp_out(m_ph, changed));
        @(posedge clk);
        #1;
        n_cyc++;
        got = {tif.phase, tif.ew_lite, tif.ns_lite, tif.phase_start};
        exp = sb_q.pop_front();
        chk("cyc", 32'(got), 32'(exp));
    endtask

    task automatic check_reset_outputs(input string tag);
        chk(tag, {27'd0, tif.phase, tif.ew_lite}, 32'd0);
        chk(tag, {30'd0, tif.ns_lite}, 32'd0);
        chk(tag, {31'd0, tif.phase_start}, 32'd0);
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        #3;
        rst_n = 1'b1;
        m_ph  = 0;
        m_el  = 0;
    endtask

    initial begin
        int last;
        rst_n      = 1'b0;
        tif.tick   = 1'b1;
        tif.ew_car = 1'b0;
        tif.ns_car = 1'b0;
        m_ph       = 0;
        m_el       = 0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset_hold");
        rst_n = 1'b1;

        cyc(1, 0, 0);
        chk("first_green", 32'(tif.ew_lite), 32'd2);
        chk("first_start", 32'(tif.phase_start), 32'd1);
        repeat (50) cyc(1, 0, 0);
        chk("hold50", 32'(tif.phase), 32'd1);

        pulse_reset();
        cyc(1, 0, 0);
        repeat (3) cyc(1, 0, 1);
        chk("min_green", 32'(tif.phase), 32'd1);
        cyc(1, 0, 1);
        chk("yellow_at4", 32'(tif.phase), 32'd2);
        repeat (2) cyc(1, 0, 1);
        chk("red_to_ns", 32'(tif.phase), 32'd3);
        cyc(1, 0, 1);
        chk("ns_green", 32'(tif.ns_lite), 32'd2);

        last = -1;
        repeat (80) begin
            cyc(1, 1, 1);
            if (tif.phase_start && tif.phase == 3'd1) begin
                if (last >= 0) chk("period22", n_cyc - last, 32'd22);
                last = n_cyc;
            end
        end

        last = -1;
        for (int i = 0; i < 210; i++) begin
            if (i % 3 == 0) cyc(1, 1, 1);
            else cyc(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if (tif.phase_start && tif.phase == 3'd1) begin
                if (last >= 0) chk("period66", n_cyc - last, 32'd66);
                last = n_cyc;
            end
        end

        for (int i = 0; i < 40 && m_ph != 5; i++) cyc(1, 1, 1);
        chk("in_ns_yellow", 32'(tif.phase), 32'd5);
        pulse_reset();
        cyc(1, 0, 0);
        chk("green_after_rst", 32'(tif.ew_lite), 32'd2);

        cyc(1, 0, 0);
        cyc(1, 0, 1);
        repeat (10) cyc(1, 0, 0);
        chk("no_latch", 32'(tif.phase), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/traffic_phase_sequencer.md
# traffic_phase_sequencer

Clocked controller for a two-way intersection: it sequences the East-West and North-South signal heads through green, yellow and all-red phases, and arbitrates green time between the two approaches from car-presence requests. Minimum and maximum green times and fixed yellow and all-red clearance times are enforced. It replaces the purely combinational car-to-light mapping at the top of the traffic-light design. Car inputs arrive already synchronised to `clk`.

## Interface
- `GREEN_MIN`, 4: minimum green time, in ticks (≥1).
- `GREEN_MAX`, 8: maximum green time while the cross direction is waiting, in ticks (≥ `GREEN_MIN`).
- `YELLOW_T`, 2: yellow duration, in ticks (≥1).
- `ALL_RED_T`, 1: all-red clearance duration, in ticks (≥1).
- `CNT_W`, 4: phase counter width; must hold max(`GREEN_MAX`, `YELLOW_T`, `ALL_RED_T`) − 1.

- `clk`  in  1  single system clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `tick`  in  1  timebase enable; all timing and state changes occur only on `clk` edges where `tick`=1.
- `ew_car`  in  1  East-West car present.
- `ns_car`  in  1  North-South car present.
- `ew_lite`  out  2  EW head: 00 RED, 01 YELLOW, 10 GREEN.
- `ns_lite`  out  2  NS head, same encoding.
- `phase`  out  3  current state encoding.
- `phase_start`  out  1  one-cycle pulse in the first cycle of each new state.

## Operation
- States (`phase` encoding):
  - `RED_TO_EW` (0)
  - `EW_GREEN` (1)
  - `EW_YELLOW` (2)
  - `RED_TO_NS` (3)
  - `NS_GREEN` (4)
  - `NS_YELLOW` (5)
- Ring order: `RED_TO_EW` → `EW_GREEN` → `EW_YELLOW` → `RED_TO_NS` → `NS_GREEN` → `NS_YELLOW` → `RED_TO_EW`.
- Counter `cnt`:
  - Cleared to 0 on every state change.
  - Otherwise increments on each tick.
  - In green states it saturates at `GREEN_MAX`−1.
- Timed states:
  - Yellow and all-red states advance on the tick where `cnt` == duration−1.
  - Yellow therefore lasts exactly `YELLOW_T` ticks, and all-red exactly `ALL_RED_T` ticks.
- Green exit, evaluated on a tick in `EW_GREEN` (mirror for NS): leave when `ns_car` && `cnt` ≥ `GREEN_MIN`−1 && (!`ew_car` || `cnt` == `GREEN_MAX`−1).
- With no cross request, green holds indefinitely.
- Green exits only when the cross request is present on the exit tick itself; requests are not latched.
- Light outputs decode from state:
  - Green state: own head GREEN.
  - Yellow state: own head YELLOW.
  - Cross head is RED in all green and yellow states; both heads RED in all-red states.
- Both heads are never simultaneously non-RED; an assertion checks this.
- Reset (async assert, any state):
  - state ← `RED_TO_EW`, `cnt` ← 0.
  - `ew_lite` = `ns_lite` = 00, `phase` = 0, `phase_start` = 0.
- Reset mid-phase discards that phase; there is no yellow on reset.

## Timing
- All outputs are registered.
- A state change taken on tick edge N is visible on `ew_lite`/`ns_lite`/`phase` immediately after edge N.
- `phase_start` is high for the single cycle following edge N, independent of `tick`.
- `tick`=0 freezes the state and `cnt`; car inputs are ignored on non-tick cycles.
- After `rst_n` deassertion, the first tick edge at which `cnt` == `ALL_RED_T`−1 enters `EW_GREEN`. With `ALL_RED_T`=1, that is the first tick.
- `phase_start` is not asserted for the reset state.

## Structure
- `traffic_pkg` holds:
  - Light encodings: `LITE_RED`, `LITE_YELLOW`, `LITE_GREEN`.
  - The state enum `phase_t` with the encodings above.
- One sub-module, `phase_timer`:
  - Tick-enabled up-counter with synchronous clear, saturation limit input and a `done` compare against a duration input.
  - The FSM drives its clear and duration.
- Lights are decoded with a registered case on the next state.

## Test plan
Default parameters, `tick`=1 every cycle unless stated.
- Reset with both cars 0:
  - During reset, both heads 00 and `phase`=0.
  - 1 tick after release, `ew_lite`=10 and `phase_start` pulses.
  - EW green holds for 50 ticks.
- In `EW_GREEN`, `ew_car`=0; `ns_car` rises at green tick 0 and is held:
  - 4th green tick: `EW_YELLOW`.
  - 2 ticks later: `RED_TO_NS`.
  - 1 tick later: `ns_lite`=10.
- Both cars held at 1:
  - Periodic sequence EW green 8 / yellow 2 / red 1 / NS green 8 / yellow 2 / red 1, i.e. a 22-tick period.
  - The both-non-RED assertion never fires.
- `tick` pulsed once every 3 cycles, same stimulus as the previous scenario:
  - All durations scale ×3 in cycles.
  - State and outputs do not change on non-tick cycles.
- `rst_n` pulsed low for half a cycle during `NS_YELLOW`:
  - Outputs go to 00/00 and `phase`=0 immediately (asynchronously).
  - EW green on the first tick after release.
- `ns_car` pulses high only on a tick where `cnt`=1 in `EW_GREEN`:
  - No phase change, because requests are not latched.
